// File: rtl/nmi2axi4l_pkg.sv
// Shared types and AXI field encodings for the NMI to AXI4-Lite bridge.
package nmi2axi4l_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREQ  = 3'd1,
    ST_WRESP = 3'd2,
    ST_RREQ  = 3'd3,
    ST_RRESP = 3'd4,
    ST_ACK   = 3'd5
  } nmi2axi4l_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DATA  = 3'b000;
  localparam logic [2:0] AXI_PROT_INSTR = 3'b100;

  // Instruction fetches are flagged through the prot[2] (instruction) bit.
  function automatic logic [2:0] ar_prot(input logic instr);
    return instr ? AXI_PROT_INSTR : AXI_PROT_DATA;
  endfunction

endpackage

// File: rtl/dffer.sv
// Register with load enable and asynchronous active-low reset to zero.
module dffer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/dffr.sv
// Plain register with asynchronous active-low reset to zero.
module dffr #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/nmi2axi4l.sv
// NMI responder to AXI4-Lite initiator bridge: one outstanding transaction,
// error reporting and a per-transaction watchdog.
module nmi2axi4l
  import nmi2axi4l_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_valid_i,
  input  logic        mem_instr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awprot_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  output logic [31:0] araddr_o,
  output logic [2:0]  arprot_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST =
    (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rsp_en;
  logic             cap_en;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       wstrb_q;
  logic             instr_q;
  logic             st_idle, st_wreq, st_wresp, st_rreq, st_rresp, st_ack;
  logic             aw_fire, w_fire, tmo_hit;

  assign st_idle  = (state_q == ST_IDLE);
  assign st_wreq  = (state_q == ST_WREQ);
  assign st_wresp = (state_q == ST_WRESP);
  assign st_rreq  = (state_q == ST_RREQ);
  assign st_rresp = (state_q == ST_RRESP);
  assign st_ack   = (state_q == ST_ACK);

  assign cap_en  = st_idle & mem_valid_i;
  assign aw_fire = awvalid_o & awready_i;
  assign w_fire  = wvalid_o & wready_i;
  assign tmo_hit = (TIMEOUT_CYC != 0) && (cnt_q == TMO_LAST);

  // Next-state, watchdog and response capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    aw_done_d = 1'b0;
    w_done_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    rsp_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (mem_valid_i) state_d = (mem_wstrb_i != 4'b0000) ? ST_WREQ : ST_RREQ;
      end
      ST_WREQ: begin
        cnt_d     = cnt_q + CNT_W'(1);
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if (tmo_hit) begin
          state_d = ST_ACK;
          err_d   = 1'b1;
          rsp_en  = 1'b1;
        end else if (aw_done_d && w_done_d) begin
          state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response landing on the expiry cycle still counts as a response.
        if (bvalid_i) begin
          state_d = ST_ACK;
          err_d   = (bresp_i != AXI_RESP_OKAY);
          rsp_en  = 1'b1;
        end else if (tmo_hit) begin
          state_d = ST_ACK;
          err_d   = 1'b1;
          rsp_en  = 1'b1;
        end
      end
      ST_RREQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tmo_hit) begin
          state_d = ST_ACK;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
          rsp_en  = 1'b1;
        end else if (arready_i) begin
          state_d = ST_RRESP;
        end
      end
      ST_RRESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rvalid_i) begin
          state_d = ST_ACK;
          err_d   = (rresp_i != AXI_RESP_OKAY);
          rdata_d = err_d ? ERR_DATA : rdata_i;
          rsp_en  = 1'b1;
        end else if (tmo_hit) begin
          state_d = ST_ACK;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
          rsp_en  = 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, watchdog and handshake-tracking registers
  dffr #(.W(3))     u_state   (.clk(clk_i), .rst_n(rst_n_i), .d(state_d),   .q(state_q));
  dffr #(.W(CNT_W)) u_cnt     (.clk(clk_i), .rst_n(rst_n_i), .d(cnt_d),     .q(cnt_q));
  dffr #(.W(1))     u_aw_done (.clk(clk_i), .rst_n(rst_n_i), .d(aw_done_d), .q(aw_done_q));
  dffr #(.W(1))     u_w_done  (.clk(clk_i), .rst_n(rst_n_i), .d(w_done_d),  .q(w_done_q));

  // Response and request capture registers
  dffer #(.W(1))  u_err   (.clk(clk_i), .rst_n(rst_n_i), .en(rsp_en), .d(err_d),       .q(err_q));
  dffer #(.W(32)) u_rdata (.clk(clk_i), .rst_n(rst_n_i), .en(rsp_en), .d(rdata_d),     .q(rdata_q));
  dffer #(.W(32)) u_addr  (.clk(clk_i), .rst_n(rst_n_i), .en(cap_en), .d(mem_addr_i),  .q(addr_q));
  dffer #(.W(32)) u_wdata (.clk(clk_i), .rst_n(rst_n_i), .en(cap_en), .d(mem_wdata_i), .q(wdata_q));
  dffer #(.W(4))  u_wstrb (.clk(clk_i), .rst_n(rst_n_i), .en(cap_en), .d(mem_wstrb_i), .q(wstrb_q));
  dffer #(.W(1))  u_instr (.clk(clk_i), .rst_n(rst_n_i), .en(cap_en), .d(mem_instr_i), .q(instr_q));

  // Outputs: registers or decodes of the state register only
  assign awvalid_o   = st_wreq & ~aw_done_q;
  assign wvalid_o    = st_wreq & ~w_done_q;
  assign bready_o    = st_wresp;
  assign arvalid_o   = st_rreq;
  assign rready_o    = st_rresp;
  assign mem_ready_o = st_ack;
  assign err_o       = st_ack & err_q;
  assign mem_rdata_o = st_ack ? rdata_q : '0;
  assign busy_o      = ~st_idle;
  assign awaddr_o    = addr_q;
  assign araddr_o    = addr_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign awprot_o    = AXI_PROT_DATA;
  assign arprot_o    = ar_prot(instr_q);

endmodule

// File: doc/nmi2axi4l.md
# nmi2axi4l

Bridge that accepts native memory interface (NMI) requests as a responder and replays each one as a single AXI4-Lite transaction as an initiator. It is the counterpart of `axi4l2nmi`. It sits between the SoC NMI crossbar and any AXI4-Lite peripheral or subsystem, such as third-party IP or an AXI interconnect. It handles one outstanding transaction, reports AXI error responses, and enforces a per-transaction timeout.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 1024: cycles allowed per transaction, counted from AXI issue to AXI response; 0 disables the timeout.
- `ERR_DATA`, default 32'hDEAD_BEEF: value returned on `mem_rdata_o` for an errored or timed-out read.

Ports:
- `clk_i` in 1: clock; all logic is on the rising edge.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `mem_valid_i` in 1: NMI request valid; held with all request fields until `mem_ready_o`.
- `mem_instr_i` in 1: request is an instruction fetch.
- `mem_addr_i` in 32: byte address.
- `mem_wdata_i` in 32: write data.
- `mem_wstrb_i` in 4: byte strobes; 4'b0000 means read.
- `mem_ready_o` out 1: one-cycle completion pulse.
- `mem_rdata_o` out 32: read data, valid while `mem_ready_o` is high.
- `awaddr_o` out 32, `awprot_o` out 3, `awvalid_o` out 1, `awready_i` in 1: AXI write address channel.
- `wdata_o` out 32, `wstrb_o` out 4, `wvalid_o` out 1, `wready_i` in 1: AXI write data channel.
- `bresp_i` in 2, `bvalid_i` in 1, `bready_o` out 1: AXI write response channel.
- `araddr_o` out 32, `arprot_o` out 3, `arvalid_o` out 1, `arready_i` in 1: AXI read address channel.
- `rdata_i` in 32, `rresp_i` in 2, `rvalid_i` in 1, `rready_o` out 1: AXI read data channel.
- `err_o` out 1: one-cycle pulse, coincident with `mem_ready_o`, when the response is non-OKAY or the transaction timed out.
- `busy_o` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, WREQ, WRESP, RREQ, RRESP, ACK.
- IDLE with `mem_valid_i`=1:
  - Capture addr, wdata, wstrb and instr into registers.
  - Non-zero wstrb goes to WREQ; zero wstrb goes to RREQ.
- WREQ: `awvalid_o` and `wvalid_o` are both asserted.
  - Each valid drops independently on its own ready handshake.
  - The AW and W handshakes may complete in either order or in the same cycle.
  - Move to WRESP once both have completed.
- WRESP: `bready_o`=1. On `bvalid_i`, latch the error flag as (`bresp_i`!=2'b00) and go to ACK.
- RREQ: `arvalid_o`=1. On `arready_i`, go to RRESP.
- RRESP: `rready_o`=1. On `rvalid_i`:
  - Latch `rdata_i`, or `ERR_DATA` if `rresp_i`!=0.
  - Latch the error flag and go to ACK.
- ACK: `mem_ready_o`=1 and `err_o`=error flag, for exactly one cycle, then IDLE.
- Write completions drive `mem_rdata_o`=0.
- Prot encoding: `awprot_o`=3'b000; `arprot_o`={`mem_instr_i` captured, 2'b00}.
- Address and data are passed through unchanged; there is no remapping.
- Timeout counter:
  - Cleared on leaving IDLE; increments in WREQ, WRESP, RREQ and RRESP.
  - When it reaches `TIMEOUT_CYC`-1 without completion: all AXI valid/ready outputs drop, FSM goes to ACK with error=1, and reads return `ERR_DATA`.
  - The abandoned AXI transaction is not tracked; this is a debug and robustness feature by decision.
- In IDLE, new requests are not sampled during ACK. A `mem_valid_i` that is high in the cycle after ACK is treated as a new request.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE; the timeout counter and captured registers reset to 0.
- All outputs are registered or are pure decodes of the state register. There is no combinational path from AXI inputs to NMI outputs.
- Request capture: cycle 0 `mem_valid_i` is seen in IDLE; cycle 1 request valid(s) are high.
- Zero-wait-state latency is 3 cycles from valid to ready, for both reads and writes. Example for a write:
  - Cycle 1: `awready`/`wready`.
  - Cycle 2: `bvalid`.
  - Cycle 3: `mem_ready_o`.
- Back-to-back throughput is one transaction per 4 cycles.
- Reset asserted mid-transaction returns the block to IDLE immediately and clears all AXI valids; no `mem_ready_o` is issued.
- A response arriving in the same cycle as the timeout expiry is treated as a normal response (response wins).

## Structure
- Package `nmi2axi4l_pkg` holds:
  - The state enum `nmi2axi4l_state_e`.
  - AXI resp constants: `AXI_RESP_OKAY`, `AXI_RESP_EXOKAY`, `AXI_RESP_SLVERR`, `AXI_RESP_DECERR`.
  - The prot field constants.
- No sub-module. State, counter and capture registers are built from the existing `dffr`/`dffer` primitives.

## Test plan
- Write 0x1234_5678, wstrb 4'b0011, to 0x4000_0010 with immediate ready and OKAY:
  - `awaddr_o`=0x4000_0010 and `wstrb_o`=4'b0011 on cycle 1.
  - `mem_ready_o` on cycle 3, `err_o`=0.
- Read from 0x0000_0100 with `mem_instr_i`=1, `arready_i` delayed 5 cycles, `rdata_i`=0xCAFE_F00D:
  - `arprot_o`=3'b100.
  - `mem_rdata_o`=0xCAFE_F00D, with ready 8 cycles after valid.
- Write with `wready_i` asserted 3 cycles before `awready_i`:
  - `wvalid_o` drops after its handshake while `awvalid_o` stays high.
  - Exactly one B handshake, then ready.
- Read with `rresp_i`=SLVERR:
  - `mem_rdata_o`=0xDEAD_BEEF and `err_o`=1, coincident with `mem_ready_o`.
- `TIMEOUT_CYC`=16 with `arready_i` tied low:
  - `arvalid_o` drops and `mem_ready_o`+`err_o` pulse 17 cycles after request capture.
- `rst_n_i` pulsed low during WRESP:
  - All outputs are 0 asynchronously and no ready is issued.
  - The next request completes normally.
